// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: sequential fetch, one branch delay slot,
// and halt detection on a taken jump to HALT_ADDRESS or a misaligned target.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDRESS = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        delay_slot,
  output logic        active,
  output logic        addr_error
);

  typedef enum logic [1:0] {
    RUN            = 2'd0,
    BRANCH_PENDING = 2'd1,
    HALTED         = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] target_q, target_next;
  logic        addr_error_q, addr_error_next;

  // Reset wins over clk_enable so a frozen core can still be restarted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= RUN;
      pc           <= RESET_VECTOR;
      target_q     <= 32'h0;
      addr_error_q <= 1'b0;
    end else if (clk_enable) begin
      state        <= state_next;
      pc           <= pc_next;
      target_q     <= target_next;
      addr_error_q <= addr_error_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    target_next     = target_q;
    addr_error_next = addr_error_q;
    case (state)
      RUN: begin
        if (branch_valid && (branch_target[1:0] != 2'b00)) begin
          addr_error_next = 1'b1;
          state_next      = HALTED;
        end else if (branch_valid) begin
          target_next = branch_target;
          pc_next     = pc + 32'd4;
          state_next  = BRANCH_PENDING;
        end else begin
          pc_next = pc + 32'd4;
        end
      end
      // Delay slot is executing; a branch decoded here is not supported.
      BRANCH_PENDING: begin
        pc_next = target_q;
        if (target_q == HALT_ADDRESS) begin
          state_next = HALTED;
        end else begin
          state_next = RUN;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = HALTED;
      end
    endcase
  end

  always_comb begin
    instr_address = pc;
    link_address  = pc + 32'd8;
    delay_slot    = (state == BRANCH_PENDING);
    active        = (state != HALTED);
    addr_error    = addr_error_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, delay slot, halts, freeze, reset.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b1;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instr_address, link_address;
  logic        delay_slot, active, addr_error;
  int          checks = 0;
  int          errors = 0;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_address(instr_address), .link_address(link_address),
    .delay_slot(delay_slot), .active(active), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; clk_enable = 1'b1; branch_valid = 1'b0; branch_target = 32'h0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    do_reset();
    checks++; if (instr_address !== 32'hBFC00000) begin errors++; $display("FAIL reset_pc got %h exp BFC00000", instr_address); end
    checks++; if (link_address !== 32'hBFC00008) begin errors++; $display("FAIL reset_link got %h exp BFC00008", link_address); end
    checks++; if ({delay_slot, active, addr_error} !== 3'b010) begin errors++; $display("FAIL reset_flags got ds/act/ae %b exp 010", {delay_slot, active, addr_error}); end
    exp_pc = 32'hBFC00000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      checks++; if (instr_address !== exp_pc) begin errors++; $display("FAIL seq_pc got %h exp %h", instr_address, exp_pc); end
      checks++; if ({delay_slot, active} !== 2'b01) begin errors++; $display("FAIL seq_flags got ds/act %b exp 01", {delay_slot, active}); end
    end
    clk_enable = 1'b0;
    step(); step();
    checks++; if (instr_address !== 32'hBFC0000C) begin errors++; $display("FAIL run_freeze_pc got %h exp BFC0000C", instr_address); end
    clk_enable = 1'b1;
  endtask

  task automatic test_branch();
    do_reset();
    step();
    branch_valid = 1'b1; branch_target = 32'hBFC00100;
    step();
    branch_valid = 1'b0;
    checks++; if (instr_address !== 32'hBFC00008) begin errors++; $display("FAIL br_slot_pc got %h exp BFC00008", instr_address); end
    checks++; if (delay_slot !== 1'b1) begin errors++; $display("FAIL br_slot_ds got %b exp 1", delay_slot); end
    checks++; if (link_address !== 32'hBFC00010) begin errors++; $display("FAIL br_slot_link got %h exp BFC00010", link_address); end
    step();
    checks++; if (instr_address !== 32'hBFC00100) begin errors++; $display("FAIL br_target_pc got %h exp BFC00100", instr_address); end
    checks++; if ({delay_slot, active} !== 2'b01) begin errors++; $display("FAIL br_target_flags got ds/act %b exp 01", {delay_slot, active}); end
    step();
    checks++; if (instr_address !== 32'hBFC00104) begin errors++; $display("FAIL br_after_pc got %h exp BFC00104", instr_address); end
  endtask

  task automatic test_halt_jump();
    do_reset();
    repeat (4) step();
    branch_valid = 1'b1; branch_target = 32'h0;
    step();
    branch_valid = 1'b0;
    checks++; if (instr_address !== 32'hBFC00014) begin errors++; $display("FAIL halt_slot_pc got %h exp BFC00014", instr_address); end
    checks++; if ({delay_slot, active} !== 2'b11) begin errors++; $display("FAIL halt_slot_flags got ds/act %b exp 11", {delay_slot, active}); end
    step();
    checks++; if (instr_address !== 32'h0) begin errors++; $display("FAIL halt_pc got %h exp 00000000", instr_address); end
    checks++; if ({delay_slot, active, addr_error} !== 3'b000) begin errors++; $display("FAIL halt_flags got ds/act/ae %b exp 000", {delay_slot, active, addr_error}); end
    for (int i = 0; i < 5; i++) begin
      branch_valid = 1'($urandom_range(0, 1));
      branch_target = $urandom & 32'hFFFFFFFC;
      step();
      checks++; if ({instr_address, active} !== {32'h0, 1'b0}) begin errors++; $display("FAIL halt_hold got pc %h act %b exp 00000000 0", instr_address, active); end
    end
    branch_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    branch_valid = 1'b1; branch_target = 32'hBFC00102;
    step();
    branch_valid = 1'b0;
    checks++; if ({addr_error, active, delay_slot} !== 3'b100) begin errors++; $display("FAIL mis_flags got ae/act/ds %b exp 100", {addr_error, active, delay_slot}); end
    checks++; if (instr_address !== 32'hBFC00004) begin errors++; $display("FAIL mis_pc got %h exp BFC00004", instr_address); end
    branch_valid = 1'b1; branch_target = 32'hBFC00200;
    step(); step();
    branch_valid = 1'b0;
    checks++; if ({instr_address, addr_error, active} !== {32'hBFC00004, 1'b1, 1'b0}) begin errors++; $display("FAIL mis_hold got pc %h ae %b act %b exp BFC00004 1 0", instr_address, addr_error, active); end
  endtask

  task automatic test_enable_freeze();
    do_reset();
    branch_valid = 1'b1; branch_target = 32'hBFC00200;
    step();
    clk_enable = 1'b0; branch_target = 32'hBFC00300;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({instr_address, delay_slot} !== {32'hBFC00004, 1'b1}) begin errors++; $display("FAIL frz_hold got pc %h ds %b exp BFC00004 1", instr_address, delay_slot); end
    end
    clk_enable = 1'b1; branch_valid = 1'b0;
    step();
    checks++; if (instr_address !== 32'hBFC00200) begin errors++; $display("FAIL frz_target got %h exp BFC00200", instr_address); end
    checks++; if (delay_slot !== 1'b0) begin errors++; $display("FAIL frz_ds got %b exp 0", delay_slot); end
  endtask

  task automatic test_wrap();
    do_reset();
    branch_valid = 1'b1; branch_target = 32'hFFFFFFF8;
    step();
    branch_valid = 1'b0;
    step(); step();
    checks++; if (instr_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc got %h exp FFFFFFFC", instr_address); end
    checks++; if (link_address !== 32'h00000004) begin errors++; $display("FAIL wrap_link got %h exp 00000004", link_address); end
    step();
    checks++; if ({instr_address, active} !== {32'h0, 1'b1}) begin errors++; $display("FAIL wrap_zero got pc %h act %b exp 00000000 1", instr_address, active); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    branch_valid = 1'b1; branch_target = 32'hBFC00400;
    step();
    branch_valid = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if ({instr_address, delay_slot, active, addr_error} !== {32'hBFC00000, 3'b010}) begin errors++; $display("FAIL rst_bp got pc %h ds/act/ae %b exp BFC00000 010", instr_address, {delay_slot, active, addr_error}); end
    step();
    checks++; if (instr_address !== 32'hBFC00004) begin errors++; $display("FAIL rst_bp_next got %h exp BFC00004", instr_address); end
    branch_valid = 1'b1; branch_target = 32'hBFC00011;
    step();
    branch_valid = 1'b0;
    checks++; if ({active, addr_error} !== 2'b01) begin errors++; $display("FAIL rst_pre_halt got act/ae %b exp 01", {active, addr_error}); end
    clk_enable = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if ({instr_address, delay_slot, active, addr_error} !== {32'hBFC00000, 3'b010}) begin errors++; $display("FAIL rst_halt got pc %h ds/act/ae %b exp BFC00000 010", instr_address, {delay_slot, active, addr_error}); end
    clk_enable = 1'b1;
    step();
    checks++; if (instr_address !== 32'hBFC00004) begin errors++; $display("FAIL rst_halt_next got %h exp BFC00004", instr_address); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_halt_jump();
    test_misaligned();
    test_enable_freeze();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch sequencer that drives `instr_address` into the Harvard instruction memory and feeds the fetched word to the MIPS datapath. Owns the PC register, enforces the single MIPS branch delay slot, and produces `active` by detecting the halt condition: a taken jump to address 0, or a misaligned branch target. The datapath decodes branches and jumps and reports the taken target; this block decides when that target reaches the fetch address.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'hBFC00000, PC value loaded on reset.
- `HALT_ADDRESS`, default 32'h00000000, taken-branch target that stops the CPU.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-low; sampled on posedge; overrides `clk_enable`.
- `clk_enable` in 1: when 0, all state holds.
- `branch_valid` in 1: instruction currently at `instr_address` is a taken branch/jump (decoded by datapath).
- `branch_target` in 32: target address, valid when `branch_valid`=1.
- `instr_address` out 32: current PC (registered).
- `link_address` out 32: `instr_address`+8, for JAL/JALR/BGEZAL/BLTZAL.
- `delay_slot` out 1: current instruction is a delay-slot instruction.
- `active` out 1: CPU running; 0 once halted.
- `addr_error` out 1: sticky; misaligned branch target seen.

## Operation
- Registers: `pc[31:0]`, `target_q[31:0]`, `state`, `addr_error`.
- States: RUN, BRANCH_PENDING, HALTED.
- Reset (`reset`=0 at posedge): `pc`=RESET_VECTOR, `target_q`=0, state=RUN, `addr_error`=0. Outputs after reset: `instr_address`=32'hBFC00000, `link_address`=32'hBFC00008, `delay_slot`=0, `active`=1, `addr_error`=0.
- RUN, `branch_valid`=0: `pc`<=`pc`+4.
- RUN, `branch_valid`=1, `branch_target[1:0]`==0: `target_q`<=`branch_target`, `pc`<=`pc`+4, go to BRANCH_PENDING.
- RUN, `branch_valid`=1, `branch_target[1:0]`!=0: `addr_error`<=1, go to HALTED, `pc` holds.
- BRANCH_PENDING (delay-slot instruction executing): `branch_valid` is ignored (branch in delay slot not supported). If `target_q`==HALT_ADDRESS: `pc`<=HALT_ADDRESS, go to HALTED. Otherwise `pc`<=`target_q`, go to RUN.
- HALTED: `pc`, `target_q` and `addr_error` hold; all inputs except `reset` are ignored.
- `active` = (state != HALTED). `delay_slot` = (state == BRANCH_PENDING). Both are decoded from registered state, with no combinational path from inputs.
- Arithmetic: `pc`+4 and `pc`+8 are modulo 2^32. Sequential wrap 32'hFFFFFFFC→0 does not halt; only a taken branch to HALT_ADDRESS does.
- A branch to HALT_ADDRESS still executes its delay slot before halting.

## Timing
- `instr_address` changes only on posedge with `clk_enable`=1 (or on reset). Instruction memory returns the word combinationally in the same cycle.
- Branch latency: `branch_valid` at cycle N (PC=P) → cycle N+1 PC=P+4 with `delay_slot`=1 → cycle N+2 PC=target.
- Halt: `active` falls at cycle N+2 for a jump to HALT_ADDRESS, or at N+1 for a misaligned target.
- `clk_enable`=0 freezes the FSM mid-branch. A pending target survives any number of disabled cycles.
- Reset during BRANCH_PENDING or HALTED: the pending target is discarded, and the next cycle fetches from RESET_VECTOR with `active`=1.
- Reset while `clk_enable`=0: reset still applies.

## Test plan
- Reset then 3 enabled cycles, no branches → `instr_address` BFC00000, BFC00004, BFC00008, BFC0000C; `active`=1; `delay_slot`=0 throughout.
- At PC=BFC00004 assert `branch_valid` with target BFC00100 → next cycle PC=BFC00008, `delay_slot`=1, `link_address`=BFC00010; following cycle PC=BFC00100, `delay_slot`=0.
- Branch to 32'h0 at PC=BFC00010 → PC=BFC00014 for one cycle, then PC=0 and `active`=0; 5 further cycles of random `branch_valid`/target leave PC=0 and `active`=0.
- Branch target BFC00102 → next cycle `addr_error`=1, `active`=0, PC holds BFC00000+offset of the branch.
- Branch taken, then `clk_enable`=0 for 4 cycles inside the delay slot, with `branch_valid`=1 and a different target → PC and `delay_slot`=1 hold; after re-enable, PC = original target.
- Reset asserted in BRANCH_PENDING, then separately in HALTED → PC=BFC00000, `active`=1, `addr_error`=0, `delay_slot`=0; the old target is never fetched.
